// File: rtl/mux2_arbiter.sv
// mux2_arbiter: two valid/ready requesters share one registered output
// channel. Ownership is granted one requester at a time, round-robin on
// contention, with the grant held for at most BURST accepted beats while
// the other requester waits.
//
// Optional feature: define MUX2_ARB_STATS_EN to add grant_cnt0/grant_cnt1,
// 16-bit saturating counts of accepted beats per requester.
//
// Handshake: a beat moves on a channel in the cycle where valid && ready are
// both high at the rising clock edge; valid must not depend on ready, data is
// sampled only on that edge, and out_data is held stable while
// out_valid && !out_ready.
module mux2_arbiter #(
  parameter int WIDTH = 4,
  parameter int BURST = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             select,
  output logic             busy,
  output logic [1:0]       state_o
`ifdef MUX2_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_served_q, last_served_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CW-1:0]    beat_cnt_inc;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_free;
  logic             acc0, acc1;

  // Handshake side: only the owner sees ready, and only when the output
  // register is empty or draining this cycle. Gated by reset so nothing is
  // granted while reset is held, even before the reset edge lands.
  always_comb begin
    out_free  = !out_valid_q || out_ready;
    in0_ready = reset && (state_q == OWN0) && out_free;
    in1_ready = reset && (state_q == OWN1) && out_free;
    acc0      = in0_valid && in0_ready;
    acc1      = in1_valid && in1_ready;
    select    = reset && (state_q == OWN1);
    busy      = reset && (state_q != IDLE);
    state_o   = state_q;
    out_valid = out_valid_q;
    out_data  = out_data_q;
  end

  // Ownership FSM next state: round-robin grant from IDLE, burst limit,
  // and early hand-over when the owner goes quiet.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    beat_cnt_d    = beat_cnt_q;
    beat_cnt_inc  = beat_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          state_d = last_served_q ? OWN0 : OWN1;
        end else if (in0_valid) begin
          state_d = OWN0;
        end else if (in1_valid) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (acc0) begin
          if (beat_cnt_inc == BURST_C) begin
            beat_cnt_d = '0;
            if (in1_valid) begin
              state_d       = OWN1;
              last_served_d = 1'b0;
            end
          end else begin
            beat_cnt_d = beat_cnt_inc;
          end
        end else if (!in0_valid) begin
          beat_cnt_d    = '0;
          last_served_d = 1'b0;
          state_d       = in1_valid ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (acc1) begin
          if (beat_cnt_inc == BURST_C) begin
            beat_cnt_d = '0;
            if (in0_valid) begin
              state_d       = OWN0;
              last_served_d = 1'b1;
            end
          end else begin
            beat_cnt_d = beat_cnt_inc;
          end
        end else if (!in1_valid) begin
          beat_cnt_d    = '0;
          last_served_d = 1'b1;
          state_d       = in0_valid ? OWN0 : IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // FSM state, round-robin memory and burst counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      beat_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      beat_cnt_q    <= beat_cnt_d;
    end
  end

  // Registered output slot: load on an accepted beat, empty when drained.
  // A beat still held at reset is discarded.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (acc0) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in0_data;
    end else if (acc1) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in1_data;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef MUX2_ARB_STATS_EN
  logic [15:0] grant_cnt0_q, grant_cnt1_q;

  // Per-requester accepted-beat counters, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (!reset) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      if (acc0 && (grant_cnt0_q != 16'hFFFF)) grant_cnt0_q <= grant_cnt0_q + 16'd1;
      if (acc1 && (grant_cnt1_q != 16'hFFFF)) grant_cnt1_q <= grant_cnt1_q + 16'd1;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_mux2_arbiter.sv
// Bench for mux2_arbiter (WIDTH=4, BURST=4): directed vectors with
// hand-computed expected output order, a scoreboard queue filled by the
// stimulus and drained by an independent output monitor.
module tb_mux2_arbiter;

  localparam int W     = 4;
  localparam int BURST = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         in0_valid, in0_ready, in1_valid, in1_ready;
  logic [W-1:0] in0_data, in1_data, out_data;
  logic         out_valid, out_ready, select, busy;
  logic [1:0]   state_w;
`ifdef MUX2_ARB_STATS_EN
  logic [15:0]  grant_cnt0, grant_cnt1;
`endif

  mux2_arbiter #(.WIDTH(W), .BURST(BURST)) dut (
    .clock     (clock),
    .reset     (reset),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .select    (select),
    .busy      (busy),
    .state_o   (state_w)
`ifdef MUX2_ARB_STATS_EN
    ,
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1)
`endif
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] src0_q[$];
  logic [W-1:0] src1_q[$];
  logic         a0, a1, sel_at;
  logic [W-1:0] mon_e;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    in0_valid = (src0_q.size() != 0);
    in0_data  = (src0_q.size() != 0) ? src0_q[0] : '0;
    in1_valid = (src1_q.size() != 0);
    in1_data  = (src1_q.size() != 0) ? src1_q[0] : '0;
  endtask

  // One clock: sample handshakes mid-cycle, then retire accepted source
  // beats and re-drive inputs just after the rising edge.
  task automatic cycle();
    @(negedge clock);
    a0     = in0_valid && in0_ready;
    a1     = in1_valid && in1_ready;
    sel_at = select;
    @(posedge clock);
    #1;
    if (a0) void'(src0_q.pop_front());
    if (a1) void'(src1_q.pop_front());
    drive_inputs();
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid || src0_q.size() != 0 || src1_q.size() != 0) && n < 60) begin
      cycle();
      n++;
    end
    chk({name, "_beats_left"}, 16'(exp_q.size()), 16'd0);
  endtask

  // ---------------- output monitor ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_beat_unexpected actual=%h expected=none", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_data !== mon_e) begin
            errors++;
            $display("FAIL out_beat actual=%h expected=%h", out_data, mon_e);
          end
        end
      end
    end
  end

  // ---------------- hard time limit ----------------
  initial begin
    #200000;
    $display("FAIL time_limit actual=running expected=finished");
    $fatal(1, "time limit");
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    logic [W-1:0] held_data;
    logic [1:0]   held_state;
    logic [8:0]   sel_bits;
    int           k, n;

    reset     = 1'b0;
    out_ready = 1'b1;
    src0_q.push_back(4'h3);
    exp_q.push_back(4'h3);
    drive_inputs();

    // Reset held 3+ cycles with a pending request: no grant, empty output.
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_in0_ready", in0_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_select", select, 1'b0);
      chk("rst_busy", busy, 1'b0);
    end
    chk("rst_out_data", out_data, 4'h0);
    chk("rst_state", state_w, 2'd0);
    reset = 1'b1;
    cycle();
    chk("rel_in0_ready", in0_ready, 1'b1);
    chk("rel_busy", busy, 1'b1);
    chk("rel_select", select, 1'b0);
    cycle();
    chk("rel_out_valid", out_valid, 1'b1);
    chk("rel_out_data", out_data, 4'h3);
    wait_drain("rel");

    // Single requester, one-cycle latency after ready.
    src0_q.push_back(4'hA);
    exp_q.push_back(4'hA);
    drive_inputs();
    #1;
    n = 0;
    while (!in0_ready && n < 10) begin
      cycle();
      n++;
    end
    chk("single_ready_seen", in0_ready, 1'b1);
    cycle();
    chk("single_out_valid", out_valid, 1'b1);
    chk("single_out_data", out_data, 4'hA);
    wait_drain("single");

    // Reset asserted mid-burst with a beat stuck in the output register.
    out_ready = 1'b0;
    src0_q.push_back(4'h1);
    src0_q.push_back(4'h2);
    src0_q.push_back(4'h3);
    drive_inputs();
    n = 0;
    while (!out_valid && n < 10) begin
      cycle();
      n++;
    end
    chk("mid_out_valid_before", out_valid, 1'b1);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_in0_ready", in0_ready, 1'b0);
    chk("mid_rst_select", select, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    cycle();
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_state", state_w, 2'd0);
    src0_q.delete();
    drive_inputs();
    cycle();
    reset = 1'b1;

    // Contention: port 0 first after reset, bursts of 4, no lost beats.
    foreach (src0_q[i]) begin end
    src0_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    src1_q = '{4'h9, 4'hA, 4'hB, 4'hC};
    exp_q  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hA, 4'hB, 4'hC, 4'h5};
    drive_inputs();
    sel_bits = 9'b011110000;
    k = 0;
    n = 0;
    while (k < 9 && n < 60) begin
      cycle();
      n++;
      if (a0 || a1) begin
        chk($sformatf("contention_sel%0d", k), sel_at, sel_bits[k]);
        k++;
      end
    end
    chk("contention_accepts", 16'(k), 16'd9);
    wait_drain("contention");
`ifdef MUX2_ARB_STATS_EN
    chk("stats_grant_cnt0", grant_cnt0, 16'd5);
    chk("stats_grant_cnt1", grant_cnt1, 16'd4);
`endif

    // Back-pressure mid-burst: port 1 wins (port 0 served last).
    src0_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    src1_q = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
    exp_q  = '{4'h8, 4'h9, 4'hA, 4'hB, 4'h1, 4'h2, 4'h3, 4'h4, 4'hC, 4'h5};
    drive_inputs();
    cycle();
    cycle();
    cycle();
    out_ready = 1'b0;
    #1;
    held_data  = out_data;
    held_state = state_w;
    chk("bp_held_data", held_data, 4'h9);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_in0_ready", in0_ready, 1'b0);
      chk("bp_in1_ready", in1_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_data", out_data, held_data);
      chk("bp_state", state_w, held_state);
    end
    out_ready = 1'b1;
    wait_drain("bp");

    // Early release: owner 0 stops after 2 beats, port 1 waiting.
    src0_q = '{4'h1, 4'h2};
    exp_q  = '{4'h1, 4'h2, 4'h6, 4'h7};
    drive_inputs();
    cycle();
    chk("early_own0_select", select, 1'b0);
    chk("early_own0_busy", busy, 1'b1);
    src1_q = '{4'h6, 4'h7};
    drive_inputs();
    cycle();
    chk("early_beat1_busy", busy, 1'b1);
    cycle();
    chk("early_beat2_select", select, 1'b0);
    chk("early_beat2_busy", busy, 1'b1);
    cycle();
    chk("early_handover_select", select, 1'b1);
    chk("early_handover_busy", busy, 1'b1);
    wait_drain("early");

    chk("final_exp_q_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 4, data width of each requester and of the shared output.
REQ-002 SHALL have parameter: BURST, 4, maximum beats (≥1) one requester holds the grant while the other requester is waiting.
REQ-003 SHALL have port: clock  in  1  rising-edge clock.
REQ-004 SHALL have port: reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: in0_valid  in  1, in0_ready  out  1, in0_data  in  WIDTH  requester 0 valid/ready channel.
REQ-006 SHALL have ports: in1_valid  in  1, in1_ready  out  1, in1_data  in  WIDTH  requester 1 valid/ready channel.
REQ-007 SHALL have ports: out_valid  out  1, out_ready  in  1, out_data  out  WIDTH  shared registered output channel.
REQ-008 SHALL have port: select  out  1  current owner; drives the shared mux2 select (0 = in0, 1 = in1).
REQ-009 SHALL have port: busy  out  1  high when state is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, OWN0, OWN1; select = 1 only in OWN1.
REQ-011 SHALL keep a last_served bit; in IDLE with both valid, the next state SHALL be OWN of the port not last_served; with one valid, OWN of that port; with none, stay IDLE.
REQ-012 SHALL register the grant: a request seen in IDLE at cycle n gives ownership at n+1.
REQ-013 SHALL drive inX_ready = (state == OWNX) && (!out_valid || out_ready), combinationally; the non-owner's ready SHALL be 0.
REQ-014 SHALL accept a beat when inX_valid && inX_ready: out_data <= inX_data, out_valid <= 1 on the next edge (one-cycle latency).
REQ-015 SHALL clear out_valid when out_ready && out_valid and no beat is accepted in that cycle.
REQ-016 SHALL count accepted beats in OWNx with beat_cnt; on the beat that makes the count BURST with the other port valid, SHALL move to the other OWN state, set last_served, and clear beat_cnt.
REQ-017 SHALL, when beat_cnt reaches BURST with the other port idle, keep ownership and clear beat_cnt.
REQ-018 SHALL, when the owner's valid is low, move directly to the other OWN state if the other port is valid; otherwise to IDLE. SHALL update last_served and clear beat_cnt.
REQ-019 SHALL not advance beat_cnt or change state on burst expiry while out_ready back-pressure blocks acceptance; out_data SHALL stay stable while out_valid && !out_ready.
REQ-020 SHALL not drop or duplicate a beat across any ownership change.

Reset
REQ-021 SHALL, on a clock edge with reset == 0, set state IDLE, out_valid 0, out_data 0, beat_cnt 0, last_served 1 (port 0 wins first), stats counters 0.
REQ-022 SHALL hold in0_ready, in1_ready, select and busy at 0 during reset, including reset asserted mid-burst; any output beat not yet taken SHALL be discarded.

Configuration
REQ-023 SHALL, with MUX2_ARB_STATS_EN defined, add outputs grant_cnt0 and grant_cnt1 (16 bits each). Each counter SHALL increment per accepted beat of its port and saturate at 16'hFFFF.
REQ-024 SHALL, without MUX2_ARB_STATS_EN, omit those ports and counters; all other behaviour is unchanged.

Verification (WIDTH=4, BURST=4)
REQ-025 SHALL cover reset: reset=0 for 3 cycles with in0_valid=1 -> in0_ready=0, out_valid=0, select=0; after release, in0_ready=1 one cycle later.
REQ-026 SHALL cover single requester: in0_valid=1, in0_data=4'hA, out_ready=1 -> out_valid=1, out_data=4'hA one cycle after in0_ready=1.
REQ-027 SHALL cover contention: both valid, out_ready=1, in0 data 1,2,3,4,5, in1 data 9,A,B,C -> out_data sequence 1,2,3,4,9,A,B,C,5 with select toggling every 4 beats.
REQ-028 SHALL cover backpressure: out_valid=1, out_ready=0 for 5 cycles -> both ready=0, out_data constant, state and beat_cnt unchanged; on out_ready=1, the flow resumes with no lost beat.
REQ-029 SHALL cover early release: owner in0 drops valid after 2 beats while in1_valid=1 -> select=1 on the next cycle, busy stays 1, and no IDLE cycle occurs.
REQ-030 SHALL cover stats: with MUX2_ARB_STATS_EN, after the REQ-027 sequence -> grant_cnt0=5, grant_cnt1=4.
